mskand_hpc2_pipe: RTL and testbench

- W-lane, d-share HPC2 masked AND (cross-domain terms plus a_i*b_i) wrapped in a 2-stage valid/ready pipeline.
- Handshakes on operands, randomness and output; all internal registers stall together.
- Internally retimes operand a and the randomness by one stage, so a and b are presented in the same cycle.
- Sits between a masked datapath and the PRNG; used wherever the S-box and other logic need many AND bits at once under flow control.

---
 rtl/mskand_hpc2_pipe.sv | 119 +++++++++++
 tb/tb_mskand_hpc2_pipe.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mskand_hpc2_pipe.sv
// W-lane, d-share HPC2 masked AND wrapped in a 2-stage valid/ready pipeline.
// Optional: define MSKAND_HPC2_CLEAR_EN to zero a stage's data registers whenever that stage drains.
module mskand_hpc2_pipe #(
  parameter int d = 2,
  parameter int W = 8,
  localparam int RND_PER_LANE = d * (d - 1) / 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W*d-1:0]            ina,
  input  logic [W*d-1:0]            inb,
  input  logic                      rnd_valid,
  output logic                      rnd_ready,
  input  logic [W*RND_PER_LANE-1:0] rnd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [W*d-1:0]            out,
  output logic                      busy
);
`ifdef MSKAND_HPC2_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic                      s0_valid_reg;
  logic                      s1_valid_reg;
  logic                      adv0;
  logic                      adv1;
  logic                      accept;
  logic                      ld1;
  logic                      clr0;
  logic                      clr1;
  logic [W*d-1:0]            a0_reg;
  logic [W*d-1:0]            b0_reg;
  logic [W*RND_PER_LANE-1:0] r0_reg;

  assign adv1      = !s1_valid_reg || out_ready;
  assign adv0      = !s0_valid_reg || adv1;
  assign accept    = in_valid && rnd_valid && adv0;
  assign ld1       = adv1 && s0_valid_reg;
  assign clr0      = CLEAR_EN && adv0 && !accept && s0_valid_reg;
  assign clr1      = CLEAR_EN && adv1 && !s0_valid_reg && s1_valid_reg;
  assign in_ready  = adv0;
  assign rnd_ready = accept;
  assign out_valid = s1_valid_reg;
  assign busy      = s0_valid_reg || s1_valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_reg <= 1'b0;
      s1_valid_reg <= 1'b0;
      a0_reg       <= '0;
      b0_reg       <= '0;
      r0_reg       <= '0;
    end else begin
      if (adv0) s0_valid_reg <= accept;
      if (adv1) s1_valid_reg <= s0_valid_reg;
      if (accept) begin
        a0_reg <= ina;
        b0_reg <= inb;
        r0_reg <= rnd;
      end else if (clr0) begin
        a0_reg <= '0;
        b0_reg <= '0;
        r0_reg <= '0;
      end
    end
  end

  // One register set per ordered share pair (i, j), i != j; r_ij and r_ji share a bit.
  for (genvar gk = 0; gk < W; gk++) begin : g_lane
    for (genvar gi = 0; gi < d; gi++) begin : g_share
      logic [d-1:0] term;
      for (genvar gj = 0; gj < d; gj++) begin : g_pair
        if (gj == gi) begin : g_diag
          assign term[gj] = 1'b0;
        end else begin : g_cross
          localparam int LO    = (gi < gj) ? gi : gj;
          localparam int HI    = (gi < gj) ? gj : gi;
          localparam int RIDX  = gk * RND_PER_LANE + LO * d - LO * (LO + 1) / 2 + (HI - 1 - LO);
          localparam bit FIRST = (gj == ((gi == 0) ? 1 : 0));
          logic v_reg;
          logic u_reg;
          logic w_reg;

          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              v_reg <= 1'b0;
              u_reg <= 1'b0;
              w_reg <= 1'b0;
            end else begin
              if (accept) begin
                v_reg <= inb[gk*d+gj] ^ rnd[RIDX];
              end else if (clr0) begin
                v_reg <= 1'b0;
              end
              if (ld1) begin
                u_reg <= (~a0_reg[gk*d+gi] & r0_reg[RIDX])
                       ^ (FIRST & a0_reg[gk*d+gi] & b0_reg[gk*d+gi]);
                w_reg <= a0_reg[gk*d+gi] & v_reg;
              end else if (clr1) begin
                u_reg <= 1'b0;
                w_reg <= 1'b0;
              end
            end
          end

          assign term[gj] = u_reg ^ w_reg;
        end
      end
      // Output XOR tree sees only stage-1 registers, so no stage-0 glitch reaches out.
      assign out[gk*d+gi] = ^term;
    end
  end

endmodule

// File: tb/tb_mskand_hpc2_pipe.sv
// Directed bench for mskand_hpc2_pipe: a d=2/W=4 instance and a d=3/W=1 instance.
module tb_mskand_hpc2_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_in_valid, a_in_ready, a_rnd_valid, a_rnd_ready;
  logic       a_out_valid, a_out_ready, a_busy;
  logic [7:0] a_ina, a_inb, a_out;
  logic [3:0] a_rnd;

  logic       b_in_valid, b_in_ready, b_rnd_valid, b_rnd_ready;
  logic       b_out_valid, b_out_ready, b_busy;
  logic [2:0] b_ina, b_inb, b_rnd, b_out;

  int n_checks = 0;
  int n_fail   = 0;

  mskand_hpc2_pipe #(.d(2), .W(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .ina(a_ina), .inb(a_inb),
    .rnd_valid(a_rnd_valid), .rnd_ready(a_rnd_ready), .rnd(a_rnd),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_out), .busy(a_busy)
  );

  mskand_hpc2_pipe #(.d(3), .W(1)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .ina(b_ina), .inb(b_inb),
    .rnd_valid(b_rnd_valid), .rnd_ready(b_rnd_ready), .rnd(b_rnd),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out), .busy(b_busy)
  );

  function automatic logic [7:0] pack2(input logic [3:0] s0, input logic [3:0] s1);
    logic [7:0] v;
    for (int k = 0; k < 4; k++) begin
      v[2*k]   = s0[k];
      v[2*k+1] = s1[k];
    end
    return v;
  endfunction

  function automatic logic [3:0] share_of(input logic [7:0] v, input int s);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = v[2*k+s];
    return r;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (a_out !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h want 00", a_out); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    n_checks++; if (a_rnd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rnd_ready: got %b want 0", a_rnd_ready); end
    n_checks++; if (b_out !== 3'b000) begin n_fail++; $display("FAIL reset_b_out: got %b want 000", b_out); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_op();
    @(posedge clk); #1;
    a_ina = pack2(4'b0101, 4'b1110);
    a_inb = pack2(4'b0011, 4'b0101);
    a_rnd = 4'b1001;
    a_in_valid = 1'b1; a_rnd_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (a_rnd_ready !== 1'b1) begin n_fail++; $display("FAIL single_rnd_ready_c0: got %b want 1", a_rnd_ready); end
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_rnd_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_out_valid_c1: got %b want 0", a_out_valid); end
    n_checks++; if (a_rnd_ready !== 1'b0) begin n_fail++; $display("FAIL single_rnd_ready_c1: got %b want 0", a_rnd_ready); end
    n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_c1: got %b want 1", a_busy); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid_c2: got %b want 1", a_out_valid); end
    n_checks++; if ((share_of(a_out, 0) ^ share_of(a_out, 1)) !== 4'b0010) begin n_fail++; $display("FAIL single_product: got %b want 0010", share_of(a_out, 0) ^ share_of(a_out, 1)); end
    n_checks++; if (share_of(a_out, 0) !== 4'b1101) begin n_fail++; $display("FAIL single_share0: got %b want 1101", share_of(a_out, 0)); end
    n_checks++; if (a_rnd_ready !== 1'b0) begin n_fail++; $display("FAIL single_rnd_ready_c2: got %b want 0", a_rnd_ready); end
    $display("single op: out=%h", a_out);
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_out_valid_c3: got %b want 0", a_out_valid); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_c3: got %b want 0", a_busy); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_q [16];
    logic [3:0] av, bv, as0, bs0;
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      if (c < 16) begin
        av  = 4'($urandom_range(0, 15));
        bv  = 4'($urandom_range(0, 15));
        as0 = 4'($urandom_range(0, 15));
        bs0 = 4'($urandom_range(0, 15));
        a_ina = pack2(as0, as0 ^ av);
        a_inb = pack2(bs0, bs0 ^ bv);
        a_rnd = 4'($urandom_range(0, 15));
        a_in_valid = 1'b1; a_rnd_valid = 1'b1;
        exp_q[c] = av & bv;
      end else begin
        a_in_valid = 1'b0; a_rnd_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 16) begin
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", c, a_in_ready); end
        n_checks++; if (a_rnd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_rnd_ready[%0d]: got %b want 1", c, a_rnd_ready); end
      end
      if (c >= 2) begin
        n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid[%0d]: got %b want 1", c - 2, a_out_valid); end
        n_checks++; if ((share_of(a_out, 0) ^ share_of(a_out, 1)) !== exp_q[c-2]) begin n_fail++; $display("FAIL b2b_product[%0d]: got %b want %b", c - 2, share_of(a_out, 0) ^ share_of(a_out, 1), exp_q[c-2]); end
        $display("b2b op %0d: product=%b", c - 2, share_of(a_out, 0) ^ share_of(a_out, 1));
      end else begin
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_fill_out_valid[%0d]: got %b want 0", c, a_out_valid); end
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b want 0", a_busy); end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    // ops: 1011&0110=0010, 1111&0101=0101, 0111&1110=0110
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    a_ina = pack2(4'b0101, 4'b1110); a_inb = pack2(4'b0011, 4'b0101); a_rnd = 4'b0110;
    a_in_valid = 1'b1; a_rnd_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_op0: got %b want 1", a_in_ready); end
    @(posedge clk); #1;
    a_ina = pack2(4'b1001, 4'b0110); a_inb = pack2(4'b1100, 4'b1001); a_rnd = 4'b1010;
    @(negedge clk);
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_op1: got %b want 1", a_in_ready); end
    @(posedge clk); #1;
    a_ina = pack2(4'b0010, 4'b0101); a_inb = pack2(4'b1000, 4'b0110); a_rnd = 4'b0011;
    @(negedge clk);
    held = a_out;
    n_checks++; if ((share_of(a_out, 0) ^ share_of(a_out, 1)) !== 4'b0010) begin n_fail++; $display("FAIL bp_stalled_product: got %b want 0010", share_of(a_out, 0) ^ share_of(a_out, 1)); end
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin @(posedge clk); #1; @(negedge clk); end
      n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_stall[%0d]: got %b want 0", c, a_in_ready); end
      n_checks++; if (a_rnd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_rnd_ready_stall[%0d]: got %b want 0", c, a_rnd_ready); end
      n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_stall[%0d]: got %b want 1", c, a_out_valid); end
      n_checks++; if (a_out !== held) begin n_fail++; $display("FAIL bp_out_stable[%0d]: got %h want %h", c, a_out, held); end
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_release: got %b want 1", a_in_ready); end
    n_checks++; if ((share_of(a_out, 0) ^ share_of(a_out, 1)) !== 4'b0010) begin n_fail++; $display("FAIL bp_out0: got %b want 0010", share_of(a_out, 0) ^ share_of(a_out, 1)); end
    $display("bp op 0: product=%b", share_of(a_out, 0) ^ share_of(a_out, 1));
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_rnd_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid1: got %b want 1", a_out_valid); end
    n_checks++; if ((share_of(a_out, 0) ^ share_of(a_out, 1)) !== 4'b0101) begin n_fail++; $display("FAIL bp_out1: got %b want 0101", share_of(a_out, 0) ^ share_of(a_out, 1)); end
    $display("bp op 1: product=%b", share_of(a_out, 0) ^ share_of(a_out, 1));
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid2: got %b want 1", a_out_valid); end
    n_checks++; if ((share_of(a_out, 0) ^ share_of(a_out, 1)) !== 4'b0110) begin n_fail++; $display("FAIL bp_out2: got %b want 0110", share_of(a_out, 0) ^ share_of(a_out, 1)); end
    $display("bp op 2: product=%b", share_of(a_out, 0) ^ share_of(a_out, 1));
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_out_valid_end: got %b want 0", a_out_valid); end
  endtask

  task automatic test_rnd_starvation();
    // a=1100, b=1010, product 1000
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      a_ina = pack2(4'b1000, 4'b0100); a_inb = pack2(4'b0110, 4'b1100); a_rnd = 4'b0011;
      a_in_valid = 1'b1; a_rnd_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (a_rnd_ready !== 1'b0) begin n_fail++; $display("FAIL starve_rnd_ready[%0d]: got %b want 0", c, a_rnd_ready); end
      n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL starve_busy[%0d]: got %b want 0", c, a_busy); end
    end
    @(posedge clk); #1;
    a_rnd_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (a_rnd_ready !== 1'b1) begin n_fail++; $display("FAIL starve_accept: got %b want 1", a_rnd_ready); end
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_rnd_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL starve_busy_after: got %b want 1", a_busy); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL starve_out_valid: got %b want 1", a_out_valid); end
    n_checks++; if ((share_of(a_out, 0) ^ share_of(a_out, 1)) !== 4'b1000) begin n_fail++; $display("FAIL starve_product: got %b want 1000", share_of(a_out, 0) ^ share_of(a_out, 1)); end
    $display("starve op: product=%b", share_of(a_out, 0) ^ share_of(a_out, 1));
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    a_ina = pack2(4'b1010, 4'b0101); a_inb = pack2(4'b1100, 4'b0011); a_rnd = 4'b0000;
    a_in_valid = 1'b1; a_rnd_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_rnd_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (a_out !== pack2(4'b1010, 4'b0101)) begin n_fail++; $display("FAIL arst_pre_out: got %h want %h", a_out, pack2(4'b1010, 4'b0101)); end
    n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre_busy: got %b want 1", a_busy); end
    rst = 1'b1;
    #1;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid: got %b want 0", a_out_valid); end
    n_checks++; if (a_out !== 8'h00) begin n_fail++; $display("FAIL arst_out: got %h want 00", a_out); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", a_busy); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready: got %b want 1", a_in_ready); end
    #2;
    rst = 1'b0;
    a_out_ready = 1'b1;
    // a=0110, b=0101, rnd=0110: product 0100, share0 0111
    @(posedge clk); #1;
    a_ina = pack2(4'b0011, 4'b0101); a_inb = pack2(4'b1111, 4'b1010); a_rnd = 4'b0110;
    a_in_valid = 1'b1; a_rnd_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (a_rnd_ready !== 1'b1) begin n_fail++; $display("FAIL arst_post_accept: got %b want 1", a_rnd_ready); end
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_rnd_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_post_out_valid_c1: got %b want 0", a_out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_post_out_valid_c2: got %b want 1", a_out_valid); end
    n_checks++; if ((share_of(a_out, 0) ^ share_of(a_out, 1)) !== 4'b0100) begin n_fail++; $display("FAIL arst_post_product: got %b want 0100", share_of(a_out, 0) ^ share_of(a_out, 1)); end
    n_checks++; if (share_of(a_out, 0) !== 4'b0111) begin n_fail++; $display("FAIL arst_post_share0: got %b want 0111", share_of(a_out, 0)); end
    $display("post-reset op: out=%h", a_out);
  endtask

  task automatic test_d3();
    logic av, bv, as0, as1, bs0, bs1;
    for (int op = 0; op < 4; op++) begin
      av  = op[1];
      bv  = op[0];
      as0 = 1'($urandom_range(0, 1)); as1 = 1'($urandom_range(0, 1));
      bs0 = 1'($urandom_range(0, 1)); bs1 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      b_ina = {av ^ as0 ^ as1, as1, as0};
      b_inb = {bv ^ bs0 ^ bs1, bs1, bs0};
      b_rnd = 3'($urandom_range(0, 7));
      b_in_valid = 1'b1; b_rnd_valid = 1'b1;
      @(negedge clk);
      n_checks++; if (b_rnd_ready !== 1'b1) begin n_fail++; $display("FAIL d3_accept[%0d]: got %b want 1", op, b_rnd_ready); end
      @(posedge clk); #1;
      b_in_valid = 1'b0; b_rnd_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL d3_out_valid_c1[%0d]: got %b want 0", op, b_out_valid); end
`ifdef MSKAND_HPC2_CLEAR_EN
      n_checks++; if (b_out !== 3'b000) begin n_fail++; $display("FAIL d3_clear_c1[%0d]: got %b want 000", op, b_out); end
`endif
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++; if (b_out_valid !== 1'b1) begin n_fail++; $display("FAIL d3_out_valid_c2[%0d]: got %b want 1", op, b_out_valid); end
      n_checks++; if ((^b_out) !== (av & bv)) begin n_fail++; $display("FAIL d3_product[%0d]: got %b want %b", op, ^b_out, av & bv); end
      $display("d3 op %0d: a=%b b=%b out=%b", op, av, bv, b_out);
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL d3_out_valid_c3[%0d]: got %b want 0", op, b_out_valid); end
`ifdef MSKAND_HPC2_CLEAR_EN
      n_checks++; if (b_out !== 3'b000) begin n_fail++; $display("FAIL d3_clear_c3[%0d]: got %b want 000", op, b_out); end
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_rnd_valid = 1'b0; a_out_ready = 1'b1;
    a_ina = '0; a_inb = '0; a_rnd = '0;
    b_in_valid = 1'b0; b_rnd_valid = 1'b0; b_out_ready = 1'b1;
    b_ina = '0; b_inb = '0; b_rnd = '0;
    test_reset();
    test_single_op();
    test_back_to_back();
    test_backpressure();
    test_rnd_starvation();
    test_async_reset();
    test_d3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
